noaa_mote_stats: RTL and testbench
==================================

Name: noaa_mote_stats

Overview:
- Sensor-side statistics block for a NOAA IoT temperature mote.
- Periodically samples a 12-bit temperature input TN over a fixed window of samples.
- At the end of each window, outputs either the window average or the population standard deviation, selected by MODE.
- Sits between the temperature ADC interface and the mote's reporting logic; DONE marks each new result.

Parameters:
- SAMPLE_PERIOD, 3, clock cycles between successive samples (>=2).
- WINDOW, 8, samples per result; power of two, 2..64; WINDOW*SAMPLE_PERIOD >= 16.

Ports:
- CLK  input  1  system clock, rising-edge active.
- RESET_N  input  1  asynchronous active-low reset.
- MODE  input  1  0 = average, 1 = standard deviation; latched with the first sample of each window.
- TN  input  12  unsigned temperature sample.
- SAMPLE  output  1  one-cycle pulse; TN is captured on the rising edge that ends this cycle.
- DONE  output  1  one-cycle pulse; AVG_SD holds a new valid result.
- AVG_SD  output  12  unsigned result; held until the next DONE.

Behaviour:
- Reset (asynchronous, RESET_N low): clears sample timer, sample count, accumulators, latched mode and FSM state. SAMPLE=0, DONE=0, AVG_SD=0.
- Sample timer:
  - Free-running counter 0..SAMPLE_PERIOD-1, starting at 0 after reset release.
  - SAMPLE is high while counter == SAMPLE_PERIOD-1, so the first SAMPLE occurs in the SAMPLE_PERIOD-th cycle after release.
- Accumulation: on each SAMPLE edge:
  - sum += TN (12+log2(WINDOW) bits).
  - sumsq += TN*TN (24+log2(WINDOW) bits).
  - count++.
  - If count was 0, MODE is latched for the whole window.
- Window end: on the WINDOW-th sample edge:
  - sum, sumsq and latched mode are snapshotted into the compute stage.
  - Accumulators and count clear.
  - The next window starts at the next SAMPLE with no gap.
- Compute FSM states: IDLE -> CALC -> (SQRT) -> OUT -> IDLE.
  - CALC (1 cycle):
    - avg = floor(sum/WINDOW), a shift.
    - var = floor((WINDOW*sumsq - sum*sum) / WINDOW^2), all unsigned and exact, never negative.
  - Average mode: CALC -> OUT. DONE is high 2 cycles after the final sample edge.
  - SD mode: CALC -> SQRT.
    - SQRT is a restoring bit-serial integer square root, 12 iterations of 1 cycle each, producing floor(sqrt(var)).
    - SQRT -> OUT. DONE is high 14 cycles after the final sample edge.
  - OUT (1 cycle): DONE=1, AVG_SD = result, registered so it is valid in the same cycle as DONE.
- Window length and overlap: the minimum window length of 16 cycles guarantees the compute stage is idle at every snapshot, so results never overlap.
- MODE changes mid-window are ignored until the next window.
- TN is sampled only on SAMPLE edges; values between samples have no effect.
- Results are always <= 4095; no saturation is needed.
- Reset mid-window or mid-compute aborts everything. The partial window and any pending result are discarded, with no DONE. Counting restarts from the beginning.

Optional Feature:
- Macro NOAA_ROUND_AVG_EN.
- Defined: average mode returns round-half-up, i.e. floor((sum + WINDOW/2) / WINDOW). The sum is widened by 1 bit so the addition cannot overflow, and the result never exceeds 4095.
- Undefined: average is truncated (floor).
- SD mode is floor in both builds.

Test Plan:
- Reset release: SAMPLE first pulses in cycle 3 after release, then every 3 cycles. DONE stays 0 until 8 samples have been taken. AVG_SD=0 throughout.
- TN=100 constant, MODE=0: AVG_SD=100 with DONE 2 cycles after the 8th sample. Same input with MODE=1: AVG_SD=0 with DONE 14 cycles after the 8th sample.
- TN=0..7, MODE=0: AVG_SD=3 (floor of 3.5); AVG_SD=4 when NOAA_ROUND_AVG_EN is defined.
- TN={2,4,4,4,5,5,7,9}, MODE=1: AVG_SD=2 (var=4).
- Extremes:
  - TN alternating 0/4095, MODE=1: AVG_SD=2047.
  - TN=4095 constant, MODE=0: AVG_SD=4095.
  - TN=4095 constant, MODE=1: AVG_SD=0.
- MODE toggled after the 3rd sample of a window: the result follows the MODE latched at the 1st sample. Asserting RESET_N low after the 5th sample: no DONE for that window, and the next result uses only the 8 post-reset samples.

Source files
------------

// File: rtl/noaa_mote_stats.sv
// noaa_mote_stats: windowed temperature statistics for a sensor mote.
// TN is sampled every SAMPLE_PERIOD cycles. After WINDOW samples the block
// reports either the window average or the population standard deviation,
// selected by the MODE value latched at the first sample of the window.
// Build option: define NOAA_ROUND_AVG_EN to round the average half-up
// instead of truncating it. The standard deviation is floored in both builds.
module noaa_mote_stats #(
  parameter int SAMPLE_PERIOD = 3,
  parameter int WINDOW        = 8
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        MODE,
  input  logic [11:0] TN,
  output logic        SAMPLE,
  output logic        DONE,
  output logic [11:0] AVG_SD
);
  localparam int LW = $clog2(WINDOW);
  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int SW = 12 + LW;        // sum width
  localparam int QW = 24 + LW;        // sum-of-squares width
  localparam int VW = 24 + 2 * LW;    // WINDOW*sumsq and sum*sum width
  localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [LW-1:0] C_LAST = LW'(WINDOW - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SQRT, S_OUT} state_t;

  // ---------------------------------------------------------------- timer
  logic [TW-1:0] tmr;

  // free-running sample timer, SAMPLE asserted on its last count
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)          tmr <= '0;
    else if (tmr == T_LAST) tmr <= '0;
    else                   tmr <= tmr + 1'b1;
  end

  assign SAMPLE = (tmr == T_LAST);

  // --------------------------------------------------------- accumulators
  logic [LW-1:0] cnt;
  logic [SW-1:0] sum, sum_nxt;
  logic [QW-1:0] sumsq, sumsq_nxt;
  logic [23:0]   tn_sq;
  logic          mode_lat, mode_cur, win_end;

  assign tn_sq     = {12'd0, TN} * {12'd0, TN};
  assign sum_nxt   = sum + SW'(TN);
  assign sumsq_nxt = sumsq + QW'(tn_sq);
  // first sample of a window takes MODE live; later samples reuse the latch
  assign mode_cur  = (cnt == '0) ? MODE : mode_lat;
  assign win_end   = SAMPLE && (cnt == C_LAST);

  // accumulate each sample; clear on the last one so windows abut
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt      <= '0;
      sum      <= '0;
      sumsq    <= '0;
      mode_lat <= 1'b0;
    end else if (SAMPLE) begin
      mode_lat <= mode_cur;
      if (cnt == C_LAST) begin
        cnt   <= '0;
        sum   <= '0;
        sumsq <= '0;
      end else begin
        cnt   <= cnt + 1'b1;
        sum   <= sum_nxt;
        sumsq <= sumsq_nxt;
      end
    end
  end

  // ------------------------------------------------------------- snapshot
  logic [SW-1:0] snap_sum;
  logic [QW-1:0] snap_sq;
  logic          snap_mode;

  // hand the completed window (including its final sample) to compute
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      snap_sum  <= '0;
      snap_sq   <= '0;
      snap_mode <= 1'b0;
    end else if (win_end) begin
      snap_sum  <= sum_nxt;
      snap_sq   <= sumsq_nxt;
      snap_mode <= mode_cur;
    end
  end

  // ------------------------------------------------------- average, var
  logic [11:0]   avg;
  logic [VW-1:0] wsq, ssq, var_full;
  logic [23:0]   var_w;

`ifdef NOAA_ROUND_AVG_EN
  // one extra bit so adding WINDOW/2 cannot wrap
  logic [SW:0] sum_rnd;
  assign sum_rnd = {1'b0, snap_sum} + (SW + 1)'(WINDOW / 2);
  assign avg     = 12'(sum_rnd >> LW);
`else
  assign avg     = 12'(snap_sum >> LW);
`endif

  // W*sumsq >= sum^2 always (Cauchy-Schwarz), so the difference is exact
  assign wsq      = VW'(snap_sq) << LW;
  assign ssq      = VW'(snap_sum) * VW'(snap_sum);
  assign var_full = wsq - ssq;
  assign var_w    = 24'(var_full >> (2 * LW));

  // ------------------------------------------------------ square root
  // restoring square root: two radicand bits per cycle, 12 cycles
  logic [23:0] rad;
  logic [13:0] rem;
  logic [11:0] root, root_nxt;
  logic [3:0]  it;
  logic [15:0] rem_sh, trial;
  logic        ge;

  assign rem_sh   = {rem, rad[23:22]};
  assign trial    = {2'b00, root, 2'b01};
  assign ge       = (rem_sh >= trial);
  assign root_nxt = {root[10:0], ge};

  // ------------------------------------------------------------------ FSM
  state_t state, state_nxt;

  // compute state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // next-state: CALC, optional 12-cycle SQRT, then one OUT cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (win_end) state_nxt = S_CALC;
      S_CALC: state_nxt = snap_mode ? S_SQRT : S_OUT;
      S_SQRT: if (it == 4'd11) state_nxt = S_OUT;
      S_OUT:  state_nxt = win_end ? S_CALC : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign DONE = (state == S_OUT);

  // datapath: load the root engine in CALC, iterate in SQRT, register result
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rad    <= '0;
      rem    <= '0;
      root   <= '0;
      it     <= '0;
      AVG_SD <= '0;
    end else begin
      case (state)
        S_CALC: begin
          rad  <= var_w;
          rem  <= '0;
          root <= '0;
          it   <= '0;
          if (!snap_mode) AVG_SD <= avg;
        end
        S_SQRT: begin
          rad  <= {rad[21:0], 2'b00};
          rem  <= 14'(ge ? (rem_sh - trial) : rem_sh);
          root <= root_nxt;
          it   <= it + 1'b1;
          if (it == 4'd11) AVG_SD <= root_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_noaa_mote_stats.sv
// Scoreboard bench for noaa_mote_stats (SAMPLE_PERIOD=3, WINDOW=8).
// The driver feeds directed windows and queues the hand-computed result with
// the cycle stamp DONE must land on; a negedge monitor checks SAMPLE cadence,
// reset values, result/latency on DONE and that AVG_SD holds between results.
module tb_noaa_mote_stats;
  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        MODE = 1'b0;
  logic [11:0] TN = '0;
  logic        SAMPLE, DONE;
  logic [11:0] AVG_SD;

  noaa_mote_stats #(.SAMPLE_PERIOD(3), .WINDOW(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .MODE(MODE), .TN(TN),
    .SAMPLE(SAMPLE), .DONE(DONE), .AVG_SD(AVG_SD)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct {
    logic [11:0] val;
    int          stamp;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          rel = 0;
  int          checks = 0;
  int          failures = 0;
  logic [11:0] hold = '0;
  logic [11:0] vec [8];

`ifdef NOAA_ROUND_AVG_EN
  localparam logic [11:0] AVG07 = 12'd4;
`else
  localparam logic [11:0] AVG07 = 12'd3;
`endif

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d", name, got, exp, cyc);
    end
  endfunction

  // monitor: everything DUT-driven is judged here
  always @(negedge CLK) begin
    if (!RESET_N) begin
      chk("rst_sample", SAMPLE, 0);
      chk("rst_done", DONE, 0);
      chk("rst_avg_sd", AVG_SD, 0);
      hold = '0;
    end else begin
      chk("sample_tick", SAMPLE, (((cyc - rel) % 3) == 2) ? 1 : 0);
      if (DONE) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("result", AVG_SD, mon_e.val);
          chk("done_latency", cyc, mon_e.stamp);
          hold = mon_e.val;
        end
      end else begin
        chk("hold", AVG_SD, hold);
      end
    end
  end

  // feed nsamp samples of vec; MODE is m0 for samples 0..2, m1 afterwards
  task automatic drive_win(input logic m0, input logic m1, input int nsamp,
                           input bit push, input logic [11:0] ev);
    int n0;
    int guard;
    for (int i = 0; i < nsamp; i++) begin
      guard = 0;
      while (SAMPLE !== 1'b1 && guard < 8) begin
        TN = 12'($urandom);   // junk between samples must be ignored
        @(negedge CLK);
        guard++;
      end
      if (SAMPLE !== 1'b1) chk("sample_timeout", 0, 1);
      TN   = vec[i];
      MODE = (i < 3) ? m0 : m1;
      @(negedge CLK);
    end
    n0 = cyc;
    if (push) sb.push_back('{ev, n0 + (m0 ? 13 : 1)});
  endtask

  task automatic do_reset();
    #1 RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    #1 RESET_N = 1'b1;
    rel = cyc;
  endtask

  initial begin
    int g;
    repeat (3) @(negedge CLK);
    #1 RESET_N = 1'b1;
    rel = cyc;

    vec = '{100, 100, 100, 100, 100, 100, 100, 100};
    drive_win(1'b0, 1'b0, 8, 1'b1, 12'd100);
    drive_win(1'b1, 1'b1, 8, 1'b1, 12'd0);

    vec = '{0, 1, 2, 3, 4, 5, 6, 7};
    drive_win(1'b0, 1'b0, 8, 1'b1, AVG07);

    vec = '{2, 4, 4, 4, 5, 5, 7, 9};
    drive_win(1'b1, 1'b1, 8, 1'b1, 12'd2);

    vec = '{0, 4095, 0, 4095, 0, 4095, 0, 4095};
    drive_win(1'b1, 1'b1, 8, 1'b1, 12'd2047);

    vec = '{4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095};
    drive_win(1'b0, 1'b0, 8, 1'b1, 12'd4095);
    drive_win(1'b1, 1'b1, 8, 1'b1, 12'd0);

    // MODE flips after the 3rd sample: the latched value wins
    vec = '{0, 1, 2, 3, 4, 5, 6, 7};        // var 336/64 -> 5, sqrt -> 2
    drive_win(1'b1, 1'b0, 8, 1'b1, 12'd2);
    vec = '{2, 4, 4, 4, 5, 5, 7, 9};        // average 5
    drive_win(1'b0, 1'b1, 8, 1'b1, 12'd5);

    // reset after the 5th sample discards the partial window
    vec = '{10, 20, 30, 40, 50, 60, 70, 80};
    drive_win(1'b0, 1'b0, 5, 1'b0, 12'd0);
    do_reset();

    // reset during SQRT discards the pending result
    vec = '{0, 4095, 0, 4095, 0, 4095, 0, 4095};
    drive_win(1'b1, 1'b1, 8, 1'b0, 12'd0);
    repeat (5) @(negedge CLK);
    do_reset();

    vec = '{10, 20, 30, 40, 50, 60, 70, 80};
    drive_win(1'b0, 1'b0, 8, 1'b1, 12'd45);
    vec = '{2, 4, 4, 4, 5, 5, 7, 9};
    drive_win(1'b1, 1'b1, 8, 1'b1, 12'd2);

    g = 0;
    while (sb.size() != 0 && g < 40) begin
      @(negedge CLK);
      g++;
    end
    chk("drain_pending", sb.size(), 0);
    repeat (3) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
